// File: rtl/mac_result_tx.sv
// mac_result_tx: captures MAC results on ld_out into a small FIFO and streams
// each word off-chip as two byte beats (low byte, then zero-extended high byte)
// over a valid/ready interface. All tx_* outputs come straight from flops.
module mac_result_tx #(
   parameter int DATA_W = 12,
   parameter int BEAT_W = 8,
   parameter int DEPTH  = 4,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_out,
   input  logic [DATA_W-1:0] sum_in,
   output logic              full,
   output logic [CW-1:0]     count,
   output logic              overflow,
   output logic [BEAT_W-1:0] tx_data,
   output logic              tx_valid,
   output logic              tx_last,
   input  logic              tx_ready
);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI} state_t;

   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   // Pointers carry one extra wrap bit above the AW-bit index so that
   // full and empty are distinguishable without a separate counter.
   logic [AW:0]       wr_ext, rd_ext;
   logic [DATA_W-1:0] mem [DEPTH];
   logic [DATA_W-1:0] head;
   logic              wr_en, pop;

   state_t            state, state_d;
   logic [DATA_W-1:0] word_q, word_d;
   logic [BEAT_W-1:0] data_d, hi_beat;
   logic              vld_d, last_d, hs;

   assign head  = mem[rd_ext[AW-1:0]];
   assign count = CW'(wr_ext - rd_ext);
   assign full  = (wr_ext[AW] != rd_ext[AW]) && (wr_ext[AW-1:0] == rd_ext[AW-1:0]);
   // full is the start-of-cycle value, so a write is dropped even if a pop
   // frees a slot at the same edge.
   assign wr_en = ld_out && !full;
   assign hs    = tx_valid && tx_ready;

   // Storage array: written only, never reset; occupancy is tracked by pointers.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ext[AW-1:0]] <= sum_in;
   end

   // FIFO pointers and sticky overflow flag.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ext   <= '0;
         rd_ext   <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_en) wr_ext <= wr_ext + PTR_ONE;
         if (pop)   rd_ext <= rd_ext + PTR_ONE;
         if (ld_out && full) overflow <= 1'b1;
      end
   end

   // High beat: upper DATA_W-8 bits of the held word, zero-extended.
   always_comb begin
      hi_beat = '0;
      hi_beat[DATA_W-BEAT_W-1:0] = word_q[DATA_W-1:BEAT_W];
   end

   // Next-state and next-output logic; outputs are computed one cycle early
   // so they can be registered without adding latency.
   always_comb begin
      state_d = state;
      word_d  = word_q;
      pop     = 1'b0;
      vld_d   = tx_valid;
      data_d  = tx_data;
      last_d  = tx_last;
      unique case (state)
         S_IDLE: begin
            if (count != '0) begin
               pop     = 1'b1;
               word_d  = head;
               state_d = S_LO;
               vld_d   = 1'b1;
               data_d  = head[BEAT_W-1:0];
               last_d  = 1'b0;
            end
         end
         S_LO: begin
            if (hs) begin
               state_d = S_HI;
               data_d  = hi_beat;
               last_d  = 1'b1;
            end
         end
         S_HI: begin
            if (hs) begin
               if (count != '0) begin
                  // Back-to-back: next word's low beat follows with no bubble.
                  pop     = 1'b1;
                  word_d  = head;
                  state_d = S_LO;
                  vld_d   = 1'b1;
                  data_d  = head[BEAT_W-1:0];
                  last_d  = 1'b0;
               end else begin
                  state_d = S_IDLE;
                  vld_d   = 1'b0;
                  data_d  = '0;
                  last_d  = 1'b0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
            data_d  = '0;
            last_d  = 1'b0;
         end
      endcase
   end

   // FSM state, held word and registered beat outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         word_q   <= '0;
         tx_valid <= 1'b0;
         tx_data  <= '0;
         tx_last  <= 1'b0;
      end else begin
         state    <= state_d;
         word_q   <= word_d;
         tx_valid <= vld_d;
         tx_data  <= data_d;
         tx_last  <= last_d;
      end
   end

endmodule

// File: tb/tb_mac_result_tx.sv
// Bench for mac_result_tx: directed vectors, expected beats queued by the
// stimulus, compared by an independent monitor on every handshake.
module tb_mac_result_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ld_out = 1'b0;
   logic [11:0] sum_in = '0;
   logic        full;
   logic [2:0]  count;
   logic        overflow;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_last;
   logic        tx_ready = 1'b0;

   int checks = 0;
   int failures = 0;
   logic [8:0] exp_q[$];   // {last, data}

   mac_result_tx #(.DATA_W(12), .BEAT_W(8), .DEPTH(4)) dut (
      .clk(clk), .rst(rst), .ld_out(ld_out), .sum_in(sum_in),
      .full(full), .count(count), .overflow(overflow),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last),
      .tx_ready(tx_ready)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_word(input logic [11:0] w);
      exp_q.push_back({1'b0, w[7:0]});
      exp_q.push_back({1'b1, 4'h0, w[11:8]});
   endtask

   task automatic drain(input string name);
      bit done = 1'b0;
      for (int i = 0; i < 200 && !done; i++) begin
         @(negedge clk);
         if (exp_q.size() == 0 && !tx_valid) done = 1'b1;
      end
      checks++;
      if (!done) begin
         failures++;
         $display("FAIL %s_drain: %0d beats still expected, tx_valid=%0b", name, exp_q.size(), tx_valid);
      end
   endtask

   // Monitor: every accepted beat must match the head of the expected queue.
   always @(negedge clk) begin
      if (!rst && tx_valid && tx_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL beat_unexpected: got data=0x%0h last=%0b, nothing expected", tx_data, tx_last);
         end else begin
            logic [8:0] e;
            e = exp_q.pop_front();
            if ({tx_last, tx_data} !== e) begin
               failures++;
               $display("FAIL beat: got last=%0b data=0x%0h expected last=%0b data=0x%0h",
                        tx_last, tx_data, e[8], e[7:0]);
            end
         end
      end
   end

   initial begin
      // Reset state
      #2;
      chk("rst_valid", tx_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_full", full, 0);
      chk("rst_ovf", overflow, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_last", tx_last, 0);
      step(); step();
      rst = 1'b0;

      // 1: single word, latency 2
      step();
      ld_out = 1'b1; sum_in = 12'hABC; tx_ready = 1'b1;
      expect_word(12'hABC);
      step(); ld_out = 1'b0;
      @(negedge clk); chk("t1_n1_valid", tx_valid, 0);
      step();
      @(negedge clk);
      chk("t1_n2_valid", tx_valid, 1); chk("t1_n2_data", tx_data, 8'hBC); chk("t1_n2_last", tx_last, 0);
      step();
      @(negedge clk);
      chk("t1_n3_valid", tx_valid, 1); chk("t1_n3_data", tx_data, 8'h0A); chk("t1_n3_last", tx_last, 1);
      step();
      @(negedge clk); chk("t1_n4_valid", tx_valid, 0);

      // 2: streaming, 8 beats with no gap
      step();
      begin
         logic [11:0] words [4];
         words = '{12'h001, 12'h123, 12'h7FF, 12'hFFF};
         for (int i = 0; i < 4; i++) begin
            ld_out = 1'b1; sum_in = words[i]; expect_word(words[i]);
            step();
         end
      end
      ld_out = 1'b0;   // now in cycle N+4; beats run N+2..N+9
      // N+2 and N+3 already checked implicitly via monitor; check gap-free N+2.. via loop
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk($sformatf("t2_valid_%0d", i + 2), tx_valid, 1);
         chk($sformatf("t2_last_%0d", i + 2), tx_last, i % 2);
         step();
      end
      drain("t2");
      chk("t2_ovf", overflow, 0);

      // 3: back-pressure during LO
      step();
      ld_out = 1'b1; sum_in = 12'h5A5; tx_ready = 1'b0;
      expect_word(12'h5A5);
      step(); ld_out = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk($sformatf("t3_hold_data_%0d", i), tx_data, 8'hA5);
         chk($sformatf("t3_hold_valid_%0d", i), tx_valid, 1);
         step();
      end
      tx_ready = 1'b1;
      drain("t3");

      // 4: overflow
      step();
      tx_ready = 1'b0;
      for (int v = 0; v < 6; v++) begin
         ld_out = 1'b1; sum_in = 12'(v);
         if (v < 5) expect_word(12'(v));
         step();
      end
      ld_out = 1'b0;
      @(negedge clk);
      chk("t4_count", count, 4);
      chk("t4_full", full, 1);
      chk("t4_ovf", overflow, 1);
      chk("t4_head_data", tx_data, 8'h00);
      step();
      tx_ready = 1'b1;
      drain("t4");
      chk("t4_ovf_sticky", overflow, 1);
      chk("t4_count_end", count, 0);

      // 5: simultaneous write and pop at HI completion
      step();
      tx_ready = 1'b0;
      for (int v = 0; v < 3; v++) begin
         ld_out = 1'b1; sum_in = 12'h310 + 12'(v); expect_word(12'h310 + 12'(v));
         step();
      end
      ld_out = 1'b0; tx_ready = 1'b1;          // LO handshake this cycle
      @(negedge clk); chk("t5_count_lo", count, 2);
      step();                                    // HI completes and pops here
      ld_out = 1'b1; sum_in = 12'h313; expect_word(12'h313);
      @(negedge clk);
      chk("t5_last_hi", tx_last, 1);
      chk("t5_count_hi", count, 2);
      step();
      ld_out = 1'b0;
      @(negedge clk); chk("t5_count_after", count, 2);
      drain("t5");

      // 6: reset mid-transfer in HI with 3 queued
      step();
      tx_ready = 1'b0;
      for (int v = 0; v < 4; v++) begin
         ld_out = 1'b1; sum_in = 12'h620 + 12'(v);
         step();
      end
      ld_out = 1'b0;
      exp_q.push_back({1'b0, 8'h20});
      tx_ready = 1'b1;
      step();
      tx_ready = 1'b0;
      @(negedge clk);
      chk("t6_in_hi_last", tx_last, 1);
      chk("t6_in_hi_count", count, 3);
      step();
      rst = 1'b1;
      #1;
      chk("t6_rst_valid", tx_valid, 0);
      chk("t6_rst_count", count, 0);
      chk("t6_rst_full", full, 0);
      chk("t6_rst_ovf", overflow, 0);
      chk("t6_pending_lo", exp_q.size(), 0);
      exp_q.delete();
      step(); step();
      rst = 1'b0;
      step();
      ld_out = 1'b1; sum_in = 12'h3C7; tx_ready = 1'b1;
      expect_word(12'h3C7);
      step(); ld_out = 1'b0;
      @(negedge clk); chk("t6_n1_valid", tx_valid, 0);
      step();
      @(negedge clk);
      chk("t6_n2_valid", tx_valid, 1); chk("t6_n2_data", tx_data, 8'hC7);
      drain("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
